// File: rtl/execute_seq.sv
// execute_seq: registered Y86-64 execute stage. Computes valE and the branch /
// cmov condition, owns the condition codes and the E->M pipeline register, and
// runs mulq on an iterative shift-add multiplier that stalls the front end.
module execute_seq #(
  parameter int         WIDTH  = 64,
  parameter bit         MUL_EN = 1'b1,
  parameter logic [2:0] CC_RST = 3'b001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       E_stat,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_ifun,
  input  logic [WIDTH-1:0] E_valA,
  input  logic [WIDTH-1:0] E_valB,
  input  logic [WIDTH-1:0] E_valC,
  input  logic [3:0]       E_dstE,
  input  logic [3:0]       E_dstM,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       W_stat,
  input  logic             M_stall,
  input  logic             M_bubble,
  input  logic             e_flush,
  output logic [WIDTH-1:0] e_valE,
  output logic [3:0]       e_dstE,
  output logic             e_cnd,
  output logic             e_busy,
  output logic [2:0]       cc,
  output logic [3:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic             M_cnd,
  output logic [WIDTH-1:0] M_valE,
  output logic [WIDTH-1:0] M_valA,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM
);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] STAT_INS = 4'h4;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] R_NONE   = 4'hF;
  localparam int         CW       = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DONE} mul_state_t;

  typedef struct packed {
    logic [3:0]       stat;
    logic [3:0]       icode;
    logic             cnd;
    logic [WIDTH-1:0] val_e;
    logic [WIDTH-1:0] val_a;
    logic [3:0]       dst_e;
    logic [3:0]       dst_m;
  } m_reg_t;

  localparam m_reg_t M_BUBBLE = '{stat: STAT_AOK, icode: I_NOP, cnd: 1'b0,
                                  val_e: '0, val_a: '0, dst_e: R_NONE, dst_m: R_NONE};

  mul_state_t         state, state_nx;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic               valid_mul, mul_load;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_of, op_ok, cc_write;
  logic [3:0]         e_stat;
  logic               zf, sf, of;
  m_reg_t             m_q;

  assign valid_mul = MUL_EN && (E_icode == I_OPQ) && (E_ifun == 4'h4) &&
                     (E_stat == STAT_AOK) && !e_flush && !M_bubble;

  // Multiply FSM state register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Multiply FSM next-state, load strobe and stall request.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_nx = state;
    mul_load = 1'b0;
    e_busy   = 1'b0;
    case (state)
      IDLE: if (valid_mul) begin
        e_busy   = 1'b1;
        mul_load = 1'b1;
        state_nx = MUL;
      end
      MUL: begin
        e_busy = 1'b1;
        if (count == CW'(1)) state_nx = DONE;
      end
      DONE: if (!M_stall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (e_flush || M_bubble) state_nx = IDLE;
  end

  // Shift-add datapath: one multiplier bit per MUL cycle, full 2W-bit product kept for OF.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
    end else if (mul_load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, E_valA};
      mplier <= E_valB;
      count  <= CW'(WIDTH);
    end else if (state == MUL) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count - CW'(1);
    end
  end

  // OPq ALU: result, overflow flag and whether the function code is legal.
  always_comb begin
    alu_res = '0;
    alu_of  = 1'b0;
    op_ok   = 1'b1;
    case (E_ifun)
      4'h0: begin
        alu_res = E_valB + E_valA;
        alu_of  = (E_valA[WIDTH-1] == E_valB[WIDTH-1]) && (alu_res[WIDTH-1] != E_valA[WIDTH-1]);
      end
      4'h1: begin
        alu_res = E_valB - E_valA;
        alu_of  = (E_valA[WIDTH-1] != E_valB[WIDTH-1]) && (alu_res[WIDTH-1] != E_valB[WIDTH-1]);
      end
      4'h2: alu_res = E_valB & E_valA;
      4'h3: alu_res = E_valB ^ E_valA;
      4'h4: begin
        op_ok = MUL_EN;
        if (MUL_EN) begin
          alu_res = acc[WIDTH-1:0];
          alu_of  = |acc[2*WIDTH-1:WIDTH];
        end
      end
      default: op_ok = 1'b0;
    endcase
  end

  // valE selection by instruction class.
  always_comb begin
    e_valE = '0;
    case (E_icode)
      4'h2:       e_valE = E_valA;
      4'h3:       e_valE = E_valC;
      4'h4, 4'h5: e_valE = E_valB + E_valC;
      4'h6:       e_valE = alu_res;
      4'h8, 4'hA: e_valE = E_valB - WIDTH'(8);
      4'h9, 4'hB: e_valE = E_valB + WIDTH'(8);
      default:    e_valE = '0;
    endcase
  end

  assign e_stat = (E_icode == I_OPQ && !op_ok) ? STAT_INS : E_stat;

  // Branch / cmov condition, always from the registered flags.
  always_comb begin
    {of, sf, zf} = cc;
    e_cnd = 1'b0;
    if (E_icode == 4'h2 || E_icode == 4'h7) begin
      case (E_ifun)
        4'h0:    e_cnd = 1'b1;
        4'h1:    e_cnd = (sf ^ of) | zf;
        4'h2:    e_cnd = sf ^ of;
        4'h3:    e_cnd = zf;
        4'h4:    e_cnd = ~zf;
        4'h5:    e_cnd = ~(sf ^ of);
        4'h6:    e_cnd = ~(sf ^ of) & ~zf;
        default: e_cnd = 1'b0;
      endcase
    end
  end

  assign e_dstE = (E_icode == 4'h2 && !e_cnd) ? R_NONE : E_dstE;

  // Flags are written only when a valid OPq actually lands in M with a clean pipe downstream.
  assign cc_write = (E_icode == I_OPQ) && op_ok && (E_ifun != 4'h4 || state == DONE) &&
                    (E_stat == STAT_AOK) && (m_stat == STAT_AOK) && (W_stat == STAT_AOK) &&
                    !M_stall && !M_bubble && !e_flush && !e_busy;

  // Condition-code register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cc <= CC_RST;
    else if (cc_write) cc <= {alu_of, alu_res[WIDTH-1], (alu_res == '0)};
  end

  // E->M pipeline register; a squashed or unfinished instruction enters M as a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              m_q <= M_BUBBLE;
    else if (M_stall)                     m_q <= m_q;
    else if (M_bubble || e_busy || e_flush) m_q <= M_BUBBLE;
    else m_q <= '{stat: e_stat, icode: E_icode, cnd: e_cnd, val_e: e_valE,
                  val_a: E_valA, dst_e: e_dstE, dst_m: E_dstM};
  end

  assign M_stat  = m_q.stat;
  assign M_icode = m_q.icode;
  assign M_cnd   = m_q.cnd;
  assign M_valE  = m_q.val_e;
  assign M_valA  = m_q.val_a;
  assign M_dstE  = m_q.dst_e;
  assign M_dstM  = m_q.dst_m;

endmodule

// File: tb/tb_execute_seq.sv
// tb_execute_seq: directed vectors with hand-computed expectations for execute_seq (WIDTH=64).
module tb_execute_seq;

  logic        clk, rst;
  logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
  logic [63:0] E_valA, E_valB, E_valC;
  logic        M_stall, M_bubble, e_flush;
  logic [63:0] e_valE, M_valE, M_valA;
  logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
  logic        e_cnd, e_busy, M_cnd;
  logic [2:0]  cc;

  int checks = 0;
  int errors = 0;
  int nbusy;
  int bad_bubbles;

  execute_seq dut (
    .clk(clk), .rst(rst),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
    .E_dstE(E_dstE), .E_dstM(E_dstM),
    .m_stat(m_stat), .W_stat(W_stat),
    .M_stall(M_stall), .M_bubble(M_bubble), .e_flush(e_flush),
    .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .e_busy(e_busy), .cc(cc),
    .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [3:0] dst);
    E_stat  = 4'h1;
    E_icode = icode;
    E_ifun  = ifun;
    E_valA  = a;
    E_valB  = b;
    E_valC  = c;
    E_dstE  = dst;
    E_dstM  = 4'hF;
  endtask

  // Starts a mulq and waits (bounded) until the stall request drops.
  task automatic run_mul(input logic [63:0] a, input logic [63:0] b);
    drive(4'h6, 4'h4, a, b, 64'd0, 4'h5);
    #1;
    nbusy = 0;
    bad_bubbles = 0;
    for (int i = 0; i < 200 && e_busy; i++) begin
      nbusy++;
      step();
      if (M_icode !== 4'h1 || M_dstE !== 4'hF) bad_bubbles++;
    end
  endtask

  initial begin
    rst = 1'b1; M_stall = 1'b0; M_bubble = 1'b0; e_flush = 1'b0;
    m_stat = 4'h1; W_stat = 4'h1;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    #12;
    check("rst_M_icode", M_icode, 4'h1);
    check("rst_M_dstE", M_dstE, 4'hF);
    check("rst_cc", cc, 3'b001);
    check("rst_busy", e_busy, 1'b0);
    rst = 1'b0;
    step();

    // add overflow into sign bit
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h2);
    #1 check("add_e_valE", e_valE, 64'h8000_0000_0000_0000);
    step();
    check("add_M_valE", M_valE, 64'h8000_0000_0000_0000);
    check("add_M_dstE", M_dstE, 4'h2);
    check("add_cc", cc, 3'b110);

    // subq 5-5 then jle on the new flags
    drive(4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h2);
    step();
    check("sub_cc", cc, 3'b001);
    check("sub_M_valE", M_valE, 64'd0);
    drive(4'h7, 4'h1, 64'd0, 64'd0, 64'h40, 4'hF);
    #1 check("jle_e_cnd", e_cnd, 1'b1);
    step();
    check("jle_M_cnd", M_cnd, 1'b1);
    drive(4'h7, 4'h2, 64'd0, 64'd0, 64'h40, 4'hF);
    #1 check("jl_e_cnd", e_cnd, 1'b0);

    // cmovl not taken, cmove taken
    drive(4'h2, 4'h2, 64'h1234, 64'd0, 64'd0, 4'h3);
    #1 check("cmovl_e_dstE", e_dstE, 4'hF);
    step();
    check("cmovl_M_valE", M_valE, 64'h1234);
    check("cmovl_M_dstE", M_dstE, 4'hF);
    drive(4'h2, 4'h3, 64'h55, 64'd0, 64'd0, 4'h3);
    #1 check("cmove_e_dstE", e_dstE, 4'h3);

    // address arithmetic
    drive(4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    #1 check("push_valE", e_valE, 64'hF8);
    drive(4'hB, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
    #1 check("pop_valE", e_valE, 64'h108);
    drive(4'h5, 4'h0, 64'd0, 64'h100, 64'h20, 4'hF);
    #1 check("mrmov_valE", e_valE, 64'h120);

    // illegal OPq function
    drive(4'h6, 4'h5, 64'd9, 64'd9, 64'd0, 4'h2);
    step();
    check("ins_M_stat", M_stat, 4'h4);
    check("ins_M_valE", M_valE, 64'd0);
    check("ins_cc", cc, 3'b001);

    // mulq 3*7
    run_mul(64'd3, 64'd7);
    check("mul_busy_cycles", nbusy, 65);
    check("mul_bubbles", bad_bubbles, 0);
    check("mul_done_valE", e_valE, 64'd21);
    step();
    check("mul_M_valE", M_valE, 64'd21);
    check("mul_M_icode", M_icode, 4'h6);
    check("mul_cc", cc, 3'b000);
    // FSM back in IDLE: a mul still sitting in E starts again
    check("mul_restart_busy", e_busy, 1'b1);
    for (int i = 0; i < 9; i++) step();
    e_flush = 1'b1;
    step();
    check("flush_busy", e_busy, 1'b0);
    check("flush_M_icode", M_icode, 4'h1);
    check("flush_M_dstE", M_dstE, 4'hF);
    check("flush_cc", cc, 3'b000);
    e_flush = 1'b0;

    // add with a faulting instruction downstream: M captures, flags untouched
    m_stat = 4'h3;
    drive(4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h2);
    step();
    check("adr_M_icode", M_icode, 4'h6);
    check("adr_M_valE", M_valE, 64'd0);
    check("adr_cc", cc, 3'b000);
    m_stat = 4'h1;

    // stall while the product waits in DONE
    run_mul(64'd2, 64'd5);
    M_stall = 1'b1;
    step();
    step();
    check("stall_busy", e_busy, 1'b0);
    check("stall_valE", e_valE, 64'd10);
    check("stall_M_hold", M_icode, 4'h1);
    M_stall = 1'b0;
    step();
    check("stall_M_valE", M_valE, 64'd10);

    // multiply overflow: 2^63 * 2
    run_mul(64'h8000_0000_0000_0000, 64'd2);
    step();
    check("mulov_M_valE", M_valE, 64'd0);
    check("mulov_cc", cc, 3'b101);

    // reset pulsed mid-MUL
    drive(4'h6, 4'h4, 64'd3, 64'd7, 64'd0, 4'h5);
    for (int i = 0; i < 5; i++) step();
    #2 rst = 1'b1;
    drive(4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
    #1;
    check("rstmul_busy", e_busy, 1'b0);
    check("rstmul_M_icode", M_icode, 4'h1);
    check("rstmul_cc", cc, 3'b001);
    rst = 1'b0;
    step();
    check("rstmul_busy_after", e_busy, 1'b0);
    check("rstmul_M_dstE", M_dstE, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_seq.md
# execute_seq

Parametrised, registered execute stage for the pipelined Y86-64 processor. Sits between the E and M pipeline registers. It computes valE, evaluates conditions against an internal condition-code register, and owns the E→M pipeline register. It adds an iterative multi-cycle `mulq` (OPq ifun 4) that stalls the front of the pipe while it runs.

## Interface
Parameters:
- `WIDTH`, 64: data width of valA/valB/valC/valE.
- `MUL_EN`, 1: 1 enables OPq ifun 4 (mulq); 0 makes it an invalid instruction.
- `CC_RST`, 3'b001: reset value of CC, bit order {OF,SF,ZF} = CC[2:0].

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `E_stat`, `E_icode`, `E_ifun` in 4 each: E-register fields.
- `E_valA`, `E_valB`, `E_valC` in WIDTH: E-register operands.
- `E_dstE`, `E_dstM` in 4: destination registers.
- `m_stat`, `W_stat` in 4: downstream status, used for CC suppression.
- `M_stall` in 1: hold the M register.
- `M_bubble` in 1: load a bubble into M and cancel the instruction in E.
- `e_flush` in 1: abort the in-flight multiply; the instruction in E is squashed.
- `e_valE` out WIDTH, `e_dstE` out 4, `e_cnd` out 1: combinational, used for forwarding.
- `e_busy` out 1: combinational stall request to F/D/E while a multiply is unfinished.
- `cc` out 3: current CC register.
- `M_stat`, `M_icode` out 4; `M_cnd` out 1; `M_valE`, `M_valA` out WIDTH; `M_dstE`, `M_dstM` out 4: the registered E→M outputs.

## Operation
- **valE by icode:**
  - 2 (cmovXX) → valA.
  - 3 (irmovq) → valC.
  - 4, 5 (rmmovq, mrmovq) → valB+valC.
  - 6 (OPq) → ALU result.
  - 7 (jXX) → 0.
  - 8, A (call, push) → valB−8.
  - 9, B (ret, pop) → valB+8.
  - Any other icode → 0.
  - All arithmetic is modulo 2^WIDTH.
- **OPq ifun:**
  - 0: add, B+A.
  - 1: sub, B−A.
  - 2: and.
  - 3: xor.
  - 4: mul, low WIDTH bits of unsigned A×B.
  - ifun>4, or ifun 4 with MUL_EN=0: e_stat = INS (4'h4), valE=0, no CC update.
- **Flags:**
  - ZF = (valE==0); SF = valE[WIDTH-1].
  - add: OF = (A[W-1]==B[W-1]) && (valE[W-1]!=A[W-1]).
  - sub: OF = (A[W-1]!=B[W-1]) && (valE[W-1]!=B[W-1]).
  - and/xor: OF = 0.
  - mul: OF = |product[2W-1:W].
- **Condition (cmovXX, jXX), by ifun:**
  - 0: 1.
  - 1: (SF^OF)|ZF.
  - 2: SF^OF.
  - 3: ZF.
  - 4: ~ZF.
  - 5: ~(SF^OF).
  - 6: ~(SF^OF)&~ZF.
  - Other ifun: 0.
  - e_cnd=0 for all other icodes.
  - Condition is always evaluated on the registered CC, never on flags being computed in the same cycle.
- **Destination:** e_dstE = 4'hF when icode 2 and e_cnd=0; otherwise E_dstE.
- **CC write:**
  - Occurs at the edge where an OPq (ifun 0–3, or a completed mul) is captured into M.
  - Requires all of: E_stat==AOK (4'h1), m_stat==AOK, W_stat==AOK, M_stall=0, M_bubble=0.
- **Multiply FSM, states IDLE → MUL → DONE:**
  - IDLE: on a valid mul (E_stat AOK, e_flush=0, M_bubble=0), load the shift-add datapath and set count=WIDTH; next state MUL.
  - MUL: one multiplier bit per cycle; count decrements; at count==1 the next state is DONE.
  - DONE: result stable; return to IDLE at the edge where M captures it (M_stall=0).
  - e_busy = 1 in IDLE-with-valid-mul and in MUL; 0 in DONE.
  - e_flush or M_bubble in any state: go to IDLE next edge, no CC write, result discarded.
- **M register update priority:**
  1. rst
  2. M_stall: hold.
  3. M_bubble or e_busy: load bubble.
  4. Otherwise capture the e_* values.
- **Bubble value:** stat=AOK, icode=1 (nop), cnd=0, valE=valA=0, dstE=dstM=4'hF.

## Timing
- Reset (asynchronous): the M register takes the bubble value, CC=CC_RST, FSM=IDLE, count=0, internal accumulator=0.
- Single-cycle instructions: e_* outputs valid in the same cycle; M_* valid after the next rising edge.
- mulq: e_busy is high for WIDTH+1 cycles; the result reaches M on the edge ending cycle WIDTH+2 (cycle 1 = first cycle the mul is in E). M holds bubbles in the meantime.
- M_stall in DONE: FSM stays in DONE and the result is held until the stall releases.
- Reset asserted mid-MUL: immediate return to IDLE, no CC write.
- The CC write and the M capture happen at the same edge. A cmov/jXX in E during the following cycle sees the new CC.

## Test plan
- add with A=0x7FFF…FFFF, B=1 → M_valE=0x8000…0000, cc=3'b110 after capture.
- subq, then jle (ifun 1) with A=5, B=5 → first edge: cc ZF=1; next cycle: e_cnd=1, M_cnd=1.
- cmovl (icode 2, ifun 2) with cc=3'b001, E_dstE=3 → e_dstE=4'hF, M_valE=valA.
- mul, WIDTH=64, A=3, B=7 → e_busy high for 65 cycles, M bubbles during that time; then M_valE=21, cc=3'b000, FSM back in IDLE.
- OPq add with m_stat=ADR (4'h3) → M captures valE, cc unchanged.
- e_flush in mul cycle 10, with a separate run where rst is pulsed mid-MUL → FSM IDLE next edge, e_busy=0, cc unchanged, M holds bubble (nop, dstE=F).
